// File: rtl/conv_mem_pkg.sv
// Shared types and sizes for the convolution memory responder.
package conv_mem_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned R     = 3;
  localparam int unsigned H     = 34;
  localparam int unsigned NFEAT = H * H;
  localparam int unsigned NWGT  = R * R;
  localparam int unsigned FAW   = $clog2(NFEAT);
  localparam int unsigned WAW   = $clog2(NWGT);

  typedef logic [W-1:0] word_t;
  typedef word_t [R-1:0] lane_arr_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/conv_mem_lane_mux.sv
// One engine read lane: weight column entry or feature row K below raddr, zero when out of range.
// With CONV_MEM_OOB_ERR_EN the lane also flags an out-of-range read.
module conv_mem_lane_mux
  import conv_mem_pkg::*;
#(
  parameter int unsigned K = 0
) (
  input  word_t raddr,
  input  logic  is_weight,
  input  word_t feat   [NFEAT],
  input  word_t weight [NWGT],
`ifdef CONV_MEM_OOB_ERR_EN
  output logic  oob,
`endif
  output word_t data
);

  localparam int unsigned FOFF = K * H;
  localparam int unsigned WOFF = K * R;

  logic [W:0] fsum;
  logic       f_ok;
  logic       w_ok;

  // Feature sum is one bit wider so a large raddr cannot wrap back into range.
  always_comb begin
    fsum = {1'b0, raddr} + (W+1)'(FOFF);
    f_ok = fsum < (W+1)'(NFEAT);
    w_ok = raddr < W'(R);
    data = '0;
    if (is_weight) begin
      if (w_ok) data = weight[WAW'(WOFF) + WAW'(raddr)];
    end else begin
      if (f_ok) data = feat[FAW'(fsum)];
    end
  end

`ifdef CONV_MEM_OOB_ERR_EN
  assign oob = is_weight ? !w_ok : !f_ok;
`endif

endmodule

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the 2D convolution engine: weight/feature/result arrays plus run sequencing.
// Optional CONV_MEM_OOB_ERR_EN adds a sticky oob_err_o flag.
module conv_mem_responder
  import conv_mem_pkg::*;
(
  input  logic      clk_i,
  input  logic      rstn_i,
  input  word_t     eng_raddr_i,
  input  logic      eng_addr_is_weight_i,
  output lane_arr_t eng_membus_o,
  input  word_t     eng_membus_i,
  input  word_t     eng_waddr_i,
  input  logic      eng_wen_i,
  output logic      eng_start_o,
  input  logic      host_wvalid_i,
  output logic      host_wready_o,
  input  logic      host_wsel_i,
  input  word_t     host_waddr_i,
  input  word_t     host_wdata_i,
  input  logic      host_start_i,
  input  logic      host_rreq_i,
  input  word_t     host_raddr_i,
  output logic      host_rvalid_o,
  output word_t     host_rdata_o,
  output logic      busy_o,
`ifdef CONV_MEM_OOB_ERR_EN
  output logic      oob_err_o,
`endif
  output logic      done_o
);

  state_t           state;
  logic [FAW-1:0]   wcnt;

  word_t weight [NWGT];
  word_t feat   [NFEAT];
  word_t result [NFEAT];

  logic  load_c;
  logic  load_wgt_ok_c;
  logic  load_feat_ok_c;
  logic  eng_wr_ok_c;
  word_t rd_word_c;

  always_comb begin
    load_c         = host_wready_o && host_wvalid_i;
    load_wgt_ok_c  = host_waddr_i < W'(NWGT);
    load_feat_ok_c = host_waddr_i < W'(NFEAT);
    eng_wr_ok_c    = eng_waddr_i < W'(NFEAT);
    rd_word_c      = (host_raddr_i < W'(NFEAT)) ? result[FAW'(host_raddr_i)] : '0;
  end

  // Read lanes are live in every state.
`ifdef CONV_MEM_OOB_ERR_EN
  logic [R-1:0] lane_oob;
`endif
  for (genvar k = 0; k < R; k++) begin : g_lane
    conv_mem_lane_mux #(.K(k)) u_lane (
      .raddr     (eng_raddr_i),
      .is_weight (eng_addr_is_weight_i),
      .feat      (feat),
      .weight    (weight),
`ifdef CONV_MEM_OOB_ERR_EN
      .oob       (lane_oob[k]),
`endif
      .data      (eng_membus_o[k])
    );
  end

  // Arrays keep their contents across reset; writes are suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (rstn_i && load_c) begin
      if (host_wsel_i && load_wgt_ok_c)   weight[WAW'(host_waddr_i)] <= host_wdata_i;
      if (!host_wsel_i && load_feat_ok_c) feat[FAW'(host_waddr_i)]   <= host_wdata_i;
    end
    if (rstn_i && state == RUN && eng_wen_i && eng_wr_ok_c) begin
      result[FAW'(eng_waddr_i)] <= eng_membus_i;
    end
  end

  // Control FSM; outputs are registered so each reflects the state it is launched into.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      wcnt          <= '0;
      eng_start_o   <= 1'b0;
      host_wready_o <= 1'b0;
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      eng_start_o   <= 1'b0;
      done_o        <= 1'b0;
      host_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          host_wready_o <= 1'b1;
          if (host_start_i) begin
            state         <= START;
            eng_start_o   <= 1'b1;
            host_wready_o <= 1'b0;
          end else if (host_rreq_i) begin
            host_rvalid_o <= 1'b1;
            host_rdata_o  <= rd_word_c;
          end
        end
        START: begin
          wcnt   <= '0;
          state  <= RUN;
          busy_o <= 1'b1;
        end
        RUN: begin
          if (eng_wen_i) begin
            if (wcnt == FAW'(NFEAT - 1)) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              wcnt <= wcnt + FAW'(1);
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          host_wready_o <= 1'b1;
          if (host_rreq_i) begin
            host_rvalid_o <= 1'b1;
            host_rdata_o  <= rd_word_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_MEM_OOB_ERR_EN
  logic oob_evt_c;

  always_comb begin
    oob_evt_c = ((state == RUN) && (|lane_oob))
             || ((state == RUN) && eng_wen_i && !eng_wr_ok_c)
             || (load_c && (host_wsel_i ? !load_wgt_ok_c : !load_feat_ok_c));
  end

  // Sticky error, cleared as a new run is launched.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      oob_err_o <= 1'b0;
    end else if (state == IDLE && host_start_i) begin
      oob_err_o <= 1'b0;
    end else if (oob_evt_c) begin
      oob_err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_mem_responder.sv
// Self-checking bench for conv_mem_responder: lane-mapping vector table plus run/readback sequences.
module tb_conv_mem_responder;
  import conv_mem_pkg::*;

  logic      clk = 1'b0;
  logic      rstn;
  word_t     eng_raddr;
  logic      eng_is_wgt;
  lane_arr_t eng_membus_out;
  word_t     eng_wdata;
  word_t     eng_waddr;
  logic      eng_wen;
  logic      eng_start;
  logic      host_wvalid;
  logic      host_wready;
  logic      host_wsel;
  word_t     host_waddr;
  word_t     host_wdata;
  logic      host_start;
  logic      host_rreq;
  word_t     host_raddr;
  logic      host_rvalid;
  word_t     host_rdata;
  logic      busy;
  logic      done;
`ifdef CONV_MEM_OOB_ERR_EN
  logic      oob_err;
`endif

  always #5 clk = ~clk;

  conv_mem_responder dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .eng_raddr_i          (eng_raddr),
    .eng_addr_is_weight_i (eng_is_wgt),
    .eng_membus_o         (eng_membus_out),
    .eng_membus_i         (eng_wdata),
    .eng_waddr_i          (eng_waddr),
    .eng_wen_i            (eng_wen),
    .eng_start_o          (eng_start),
    .host_wvalid_i        (host_wvalid),
    .host_wready_o        (host_wready),
    .host_wsel_i          (host_wsel),
    .host_waddr_i         (host_waddr),
    .host_wdata_i         (host_wdata),
    .host_start_i         (host_start),
    .host_rreq_i          (host_rreq),
    .host_raddr_i         (host_raddr),
    .host_rvalid_o        (host_rvalid),
    .host_rdata_o         (host_rdata),
    .busy_o               (busy),
`ifdef CONV_MEM_OOB_ERR_EN
    .oob_err_o            (oob_err),
`endif
    .done_o               (done)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic  sel;
    word_t addr;
    word_t e0;
    word_t e1;
    word_t e2;
  } vec_t;

  vec_t  vecs [9];
  word_t exp_q [$];
  word_t res_model [NFEAT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input word_t a, input word_t d);
    host_wvalid = 1'b1;
    host_wsel   = sel;
    host_waddr  = a;
    host_wdata  = d;
    tick();
    host_wvalid = 1'b0;
  endtask

  // Expected readback is pushed on request and popped when rvalid appears.
  task automatic rd(input word_t a);
    host_rreq  = 1'b1;
    host_raddr = a;
    exp_q.push_back((a < NFEAT) ? res_model[a] : '0);
    tick();
    host_rreq = 1'b0;
    chk("rd_rvalid", 64'(host_rvalid), 64'd1);
    if (exp_q.size() == 0) begin
      chk("rd_queue_empty", 64'd1, 64'd0);
    end else begin
      chk("rd_data", 64'(host_rdata), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic start_run();
    host_start = 1'b1;
    host_rreq  = 1'b1;
    host_raddr = 32'd5;
    chk("start_pre", 64'(eng_start), 64'd0);
    tick();
    host_start = 1'b0;
    host_rreq  = 1'b0;
    chk("start_pulse", 64'(eng_start), 64'd1);
    chk("start_busy", 64'(busy), 64'd0);
    chk("start_rreq_ignored", 64'(host_rvalid), 64'd0);
    tick();
    chk("start_one_cycle", 64'(eng_start), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_wready", 64'(host_wready), 64'd0);
  endtask

  initial begin
    int bad;
    vecs[0] = '{1'b1, 32'd1,          32'd2,    32'd5,    32'd8};
    vecs[1] = '{1'b1, 32'd0,          32'd1,    32'd4,    32'd7};
    vecs[2] = '{1'b1, 32'd2,          32'd3,    32'd6,    32'd9};
    vecs[3] = '{1'b1, 32'd3,          32'd0,    32'd0,    32'd0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'd0,    32'd0,    32'd0};
    vecs[5] = '{1'b0, 32'd35,         32'd35,   32'd69,   32'd103};
    vecs[6] = '{1'b0, 32'd1155,       32'd1155, 32'd0,    32'd0};
    vecs[7] = '{1'b0, 32'd1100,       32'd1100, 32'd1134, 32'd0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'd0,    32'd0,    32'd0};

    rstn = 1'b0; eng_raddr = '0; eng_is_wgt = 1'b0; eng_wdata = '0; eng_waddr = '0;
    eng_wen = 1'b0; host_wvalid = 1'b0; host_wsel = 1'b0; host_waddr = '0; host_wdata = '0;
    host_start = 1'b0; host_rreq = 1'b0; host_raddr = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_start", 64'(eng_start), 64'd0);
    chk("rst_rvalid", 64'(host_rvalid), 64'd0);
    chk("rst_rdata", 64'(host_rdata), 64'd0);
`ifdef CONV_MEM_OOB_ERR_EN
    chk("rst_oob", 64'(oob_err), 64'd0);
`endif
    rstn = 1'b1;
    tick();
    chk("idle_wready", 64'(host_wready), 64'd1);

    for (int i = 0; i < int'(NWGT); i++) load(1'b1, word_t'(i), word_t'(i + 1));
    for (int i = 0; i < int'(NFEAT); i++) load(1'b0, word_t'(i), word_t'(i));
    load(1'b1, 32'd9, 32'd77);
    load(1'b0, 32'(NFEAT), 32'd55);
`ifdef CONV_MEM_OOB_ERR_EN
    chk("oob_set_on_drop", 64'(oob_err), 64'd1);
`endif

    for (int v = 0; v < 9; v++) begin
      eng_is_wgt = vecs[v].sel;
      eng_raddr  = vecs[v].addr;
      #1;
      chk($sformatf("lane0_v%0d", v), 64'(eng_membus_out[0]), 64'(vecs[v].e0));
      chk($sformatf("lane1_v%0d", v), 64'(eng_membus_out[1]), 64'(vecs[v].e1));
      chk($sformatf("lane2_v%0d", v), 64'(eng_membus_out[2]), 64'(vecs[v].e2));
    end

    rd(32'd1156);

    // Full run: 1156 engine writes with data = addr.
    start_run();
`ifdef CONV_MEM_OOB_ERR_EN
    chk("oob_cleared_by_start", 64'(oob_err), 64'd0);
`endif
    load(1'b1, 32'd0, 32'd999);
    chk("run_load_blocked", 64'(host_wready), 64'd0);
    host_rreq = 1'b1; host_raddr = 32'd5;
    tick();
    host_rreq = 1'b0;
    chk("run_read_ignored", 64'(host_rvalid), 64'd0);

    bad = 0;
    for (int i = 0; i < int'(NFEAT); i++) begin
      eng_wen = 1'b1; eng_waddr = word_t'(i); eng_wdata = word_t'(i);
      res_model[i] = word_t'(i);
      tick();
      if (i < int'(NFEAT) - 1 && (done || !busy)) bad++;
    end
    eng_wen = 1'b0;
    chk("run_flags_during_writes", 64'(bad), 64'd0);
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("back_idle_wready", 64'(host_wready), 64'd1);

    eng_is_wgt = 1'b1; eng_raddr = 32'd0;
    #1;
    chk("weight_untouched_by_run_load", 64'(eng_membus_out[0]), 64'd1);

    rd(32'd500);
    rd(32'd0);
    rd(32'd1155);
    tick();
    tick();
    chk("rdata_hold", 64'(host_rdata), 64'd1155);
    chk("rvalid_single", 64'(host_rvalid), 64'd0);
    rd(32'd1156);
    rd(32'hFFFF_FFFF);

    // Second run aborted by reset on the 600th write.
    start_run();
    for (int i = 0; i < 599; i++) begin
      eng_wen = 1'b1; eng_waddr = word_t'(i); eng_wdata = word_t'(i + 5000);
      res_model[i] = word_t'(i + 5000);
      tick();
    end
    eng_waddr = 32'd599; eng_wdata = 32'd5599;
    rstn = 1'b0;
    tick();
    eng_wen = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    rstn = 1'b1;
    tick();
    chk("abort_no_done_late", 64'(done), 64'd0);
    chk("abort_idle_wready", 64'(host_wready), 64'd1);
    rd(32'd10);
    rd(32'd598);
    rd(32'd700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_mem_responder.md
Name: conv_mem_responder

Overview:
- Memory-side responder for the 2D convolution engine.
- Holds an R×R weight array, an H×H feature array and an H×H result array, all flip-flop based.
- Answers the engine's read bus combinationally with R row-parallel words and captures the engine's writes.
- Gives a host valid/ready load port, a result readback port and start/done sequencing around one engine run.

Parameters:
- W, 32: data/address word width.
- R, 3: kernel size; number of parallel read lanes.
- H, 34: feature/result plane edge length.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  synchronous active-low reset.
- eng_raddr_i  in  W  engine read address.
- eng_addr_is_weight_i  in  1  1 = weight region, 0 = feature region.
- eng_membus_o  out  W×R  read data lanes [R], to the engine's membus_i.
- eng_membus_i  in  W  engine write data.
- eng_waddr_i  in  W  engine write address.
- eng_wen_i  in  1  engine write enable.
- eng_start_o  out  1  one-cycle start pulse to the engine.
- host_wvalid_i  in  1  host load request.
- host_wready_o  out  1  load accepted.
- host_wsel_i  in  1  1 = weight, 0 = feature.
- host_waddr_i  in  W  load address (linear).
- host_wdata_i  in  W  load data.
- host_start_i  in  1  request a run.
- host_rreq_i  in  1  result read request.
- host_raddr_i  in  W  result address.
- host_rvalid_o  out  1  result data valid.
- host_rdata_o  out  W  result data.
- busy_o  out  1  engine run in progress.
- done_o  out  1  one-cycle pulse at run end.

Behaviour:
- Reset (synchronous, rstn_i low at posedge):
  - Control: state=IDLE; counters 0; all control outputs 0; host_rdata_o 0.
  - Arrays: contents not reset.
- FSM states IDLE, START, RUN, DONE.
  - IDLE:
    - host_wready_o=1.
    - Accept a load on host_wvalid_i: wsel=1 writes weight[addr] if addr<R*R; wsel=0 writes feat[addr] if addr<H*H. Out-of-range loads are accepted and dropped.
    - host_start_i (priority over a same-cycle rreq; a same-cycle load is still accepted) -> START.
  - START: eng_start_o=1 for exactly this cycle; write counter cleared; -> RUN.
  - RUN:
    - busy_o=1; host_wready_o=0; host reads ignored.
    - Each eng_wen_i cycle writes result[eng_waddr_i] (if < H*H) and increments the write counter.
    - When the counter reaches H*H-1 on an eng_wen_i cycle -> DONE.
  - DONE: done_o=1 for one cycle; -> IDLE.
- Engine read mapping, combinational, zero latency (the engine samples in the same cycle). For lane k in 0..R-1:
  - Weight: eng_membus_o[k] = weight[k*R + raddr] if raddr<R, else 0.
  - Feature: eng_membus_o[k] = feat[raddr + k*H] if raddr + k*H < H*H, else 0 (bottom-edge zero padding).
  - The read port is live in every state.
- Host result read:
  - Allowed in IDLE and DONE.
  - One-cycle latency: host_rvalid_o=1 on the cycle after host_rreq_i.
  - host_rdata_o = result[addr], or 0 if addr ≥ H*H.
  - host_rdata_o holds its value until the next accepted request.
- Arithmetic: address compares are unsigned, full W bits; no wrap. Engine write and host load cannot coincide (host blocked in RUN).
- Reset mid-RUN: returns to IDLE and does not pulse done_o. Array contents are retained.

Optional Feature:
- CONV_MEM_OOB_ERR_EN.
- When defined:
  - Adds output oob_err_o (1 bit, reset 0).
  - Sticky-set by any out-of-range engine read while in RUN, any out-of-range eng_wen_i write, or any dropped host load.
  - Cleared on entry to START.
- When not defined: the port is absent, and out-of-range accesses are silently zeroed or dropped.

Decomposition:
- Package conv_mem_pkg holds:
  - the state enum (IDLE/START/RUN/DONE);
  - the word type;
  - constants R, H, NFEAT=H*H, NWGT=R*R;
  - a lane-array typedef.
- Sub-module conv_mem_lane_mux: a single feature-plus-weight read lane, with lane index k as a parameter. The top instantiates R of them.

Test Plan:
- Load weight[i]=i+1 (i=0..8), raddr=1, weight-select -> lanes = {2,5,8}.
- Load feat[i]=i, raddr=35, feature-select -> lanes = {35,69,103}.
- Feature read with raddr=1155 -> lanes = {1155,0,0}.
- host_start_i pulse:
  - eng_start_o high exactly one cycle later, for one cycle.
  - busy_o high while eng_wen_i is driven 1156 times with data=addr.
  - done_o pulses the cycle after the 1156th write.
  - Readback of addr 500 returns 500 with rvalid one cycle after rreq.
- During RUN: host_wvalid_i=1 -> host_wready_o=0, array unchanged. Host read of an address ≥ 1156 in IDLE -> rdata 0.
- rstn_i low at write 600 of a run:
  - Next cycle state is IDLE with busy_o=0 and no done_o.
  - Earlier result writes are still readable.
  - With CONV_MEM_OOB_ERR_EN, a host load at address 9 with weight-select sets oob_err_o, and the next START clears it.
